conv_out_sched: RTL
===================

# conv_out_sched

Synchronous scheduler for one convolution layer's output stage. It counts accumulated MAC taps per output neuron and pulses the neuron-ready strobe. It walks neurons across each output plane and across output channels. For every finished neuron it issues a write, delayed to match the accumulator pipeline, with the packed output-buffer address and the channel lane select. It sits between the input-feed/MAC datapath and the output feature-map RAM, and replaces free-running ready counters with a single clocked controller.

## Interface
- TAPS, 25: MAC taps accumulated per output neuron, ≥ 1.
- PLANE_SIZE, 784: neurons per output plane (R*C), ≥ 1.
- OUT_CH, 16: output channels in the layer; must be a multiple of CH_PER_GROUP.
- CH_PER_GROUP, 4: channels packed per output word; must be a power of 2.
- GROUP_STRIDE, 784: address distance between channel groups.
- WR_DELAY, 2: cycles from neuron_rdy to wr_en, ≥ 1.
- ADDR_W, 16: output address width.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse that starts a layer; accepted only in IDLE.
- in_valid  in  1  one MAC tap is presented this cycle.
- acc_clr  out  1  marks the first tap of a neuron; high with that tap's in_valid.
- neuron_rdy  out  1  one-cycle pulse; the last tap of the neuron is being accumulated this cycle.
- plane_rdy  out  1  one-cycle pulse, coincident with the last neuron_rdy of a plane.
- wr_en  out  1  write strobe to the output RAM.
- wr_addr  out  ADDR_W  write address, valid with wr_en.
- wr_lane  out  log2(CH_PER_GROUP)  lane within the word, valid with wr_en.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse when the layer completes.

## Operation
- States:
  - IDLE: waits for start, then goes to RUN and clears all counters.
  - RUN: sequences the layer; goes to DRAIN after the last tap of the last neuron of the last channel.
  - DRAIN: waits until the write delay line is empty, then goes to DONE.
  - DONE: holds for one cycle with done=1, then returns to IDLE.
- Counters:
  - tap_cnt counts 0..TAPS-1.
  - pix_cnt counts 0..PLANE_SIZE-1.
  - ch_cnt counts 0..OUT_CH-1.
- Counting in RUN:
  - A cycle with in_valid=0 holds every counter and strobe.
  - On in_valid=1: acc_clr = (tap_cnt==0).
  - If tap_cnt==TAPS-1: neuron_rdy=1, tap_cnt goes to 0 and pix_cnt advances. Otherwise tap_cnt increments.
  - When pix_cnt==PLANE_SIZE-1 and the neuron completes: plane_rdy=1, pix_cnt goes to 0 and ch_cnt increments.
- TAPS==1: acc_clr and neuron_rdy are both high on every valid tap.
- Address:
  - addr = (ch_cnt / CH_PER_GROUP) * GROUP_STRIDE + pix_cnt, truncated modulo 2^ADDR_W.
  - lane = ch_cnt % CH_PER_GROUP.
  - Both are sampled in the neuron_rdy cycle, before the counters advance.
- Write delay line: {neuron_rdy, addr, lane} passes through WR_DELAY register stages to {wr_en, wr_addr, wr_lane}.
  - The line shifts every cycle, independent of in_valid.
  - It keeps shifting in DRAIN.
- Ignored inputs:
  - in_valid outside RUN, including in DRAIN.
  - start outside IDLE, including start held high during DONE.

## Timing
- Reset values:
  - state=IDLE.
  - All counters 0.
  - All delay stages 0.
  - acc_clr, neuron_rdy, plane_rdy, wr_en, busy and done are 0.
  - wr_addr=0 and wr_lane=0.
- Asserting rst_n mid-layer aborts immediately. Writes already in flight are discarded, with no wr_en after reset.
- Output timing:
  - acc_clr, neuron_rdy and plane_rdy are combinational from state, counters and in_valid, in the same cycle as the tap.
  - wr_en, wr_addr, wr_lane, busy and done are registered.
- start sampled high at edge k puts state in RUN after edge k, so busy=1 from cycle k+1. The first tap is accepted at cycle k+1 at the earliest.
- A neuron_rdy at cycle n gives wr_en at cycle n+WR_DELAY.
- The final neuron_rdy is at cycle n:
  - RUN→DRAIN at edge n.
  - The last wr_en is at cycle n+WR_DELAY.
  - DONE (done=1, busy=0) is at cycle n+WR_DELAY+1.
  - IDLE is at cycle n+WR_DELAY+2.
- Total valid taps per layer = TAPS*PLANE_SIZE*OUT_CH.
- Writes per layer = PLANE_SIZE*OUT_CH.
- plane_rdy pulses per layer = OUT_CH.

## Test plan
- Defaults, continuous in_valid=1 after start:
  - neuron_rdy at taps 25, 50, …
  - First write has addr 0, lane 0, exactly 2 cycles after the first neuron_rdy.
  - 12544 writes and 16 plane_rdy pulses in total.
  - The write after the 4th plane_rdy has addr 784, lane 0.
  - The last write has addr 3135, lane 3.
  - done 3 cycles after the final neuron_rdy.
- Defaults, in_valid random at 50%:
  - Same write sequence and count as the continuous case.
  - The counters freeze on every invalid cycle.
- TAPS=1, PLANE_SIZE=4, OUT_CH=4, WR_DELAY=1:
  - acc_clr and neuron_rdy are high on every valid tap.
  - Writes have addr 0,1,2,3 repeated four times, with lanes 0,1,2,3 per pass.
- Pulse start during RUN and during DRAIN:
  - Ignored; the layer completes with unchanged write count.
  - in_valid=1 during DRAIN produces no extra neuron_rdy.
- Drop rst_n low on the cycle of a neuron_rdy mid-layer:
  - All outputs go to 0 asynchronously.
  - No wr_en follows.
  - The next start restarts at addr 0, lane 0.
- Back-to-back layers: pulse start in the cycle after done.
  - The second layer's first write is addr 0, lane 0.
  - The first write's timing matches the first layer's.

Source files
------------

// File: rtl/conv_out_sched.sv
// Output-stage scheduler for one convolution layer: counts MAC taps per neuron, walks
// pixels and channels, and issues pipeline-aligned packed writes to the output RAM.
module conv_out_sched #(
    parameter int unsigned TAPS         = 25,
    parameter int unsigned PLANE_SIZE   = 784,
    parameter int unsigned OUT_CH       = 16,
    parameter int unsigned CH_PER_GROUP = 4,
    parameter int unsigned GROUP_STRIDE = 784,
    parameter int unsigned WR_DELAY     = 2,
    parameter int unsigned ADDR_W       = 16,
    localparam int unsigned LANE_W      = (CH_PER_GROUP > 1) ? $clog2(CH_PER_GROUP) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              acc_clr,
    output logic              neuron_rdy,
    output logic              plane_rdy,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [LANE_W-1:0] wr_lane,
    output logic              busy,
    output logic              done
);

    localparam int unsigned TAP_W = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int unsigned PIX_W = (PLANE_SIZE > 1) ? $clog2(PLANE_SIZE) : 1;
    localparam int unsigned CH_W  = (OUT_CH > 1) ? $clog2(OUT_CH) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e            state_q;
    logic [TAP_W-1:0]  tap_q;
    logic [PIX_W-1:0]  pix_q;
    logic [CH_W-1:0]   ch_q;
    logic              busy_q;
    logic              done_q;

    logic              tap_ok;
    logic              tap_last;
    logic              pix_last;
    logic              ch_last;
    logic [31:0]       addr_full;
    logic [ADDR_W-1:0] addr_now;
    logic [LANE_W-1:0] lane_now;
    logic              line_empty_next;

    // Bit 0 is the newest stage; the top bit drives wr_en.
    logic [WR_DELAY-1:0] v_q;
    logic [ADDR_W-1:0]   addr_q [WR_DELAY];
    logic [LANE_W-1:0]   lane_q [WR_DELAY];

    always_comb begin
        tap_ok     = (state_q == StRun) && in_valid;
        tap_last   = (tap_q == TAP_W'(TAPS - 1));
        pix_last   = (pix_q == PIX_W'(PLANE_SIZE - 1));
        ch_last    = (ch_q == CH_W'(OUT_CH - 1));
        acc_clr    = tap_ok && (tap_q == '0);
        neuron_rdy = tap_ok && tap_last;
        plane_rdy  = neuron_rdy && pix_last;
        addr_full  = (32'(ch_q) / CH_PER_GROUP) * GROUP_STRIDE + 32'(pix_q);
        addr_now   = ADDR_W'(addr_full);
        lane_now   = LANE_W'(32'(ch_q) % CH_PER_GROUP);
        // Only the oldest stage may still hold a write once the line shifts again.
        line_empty_next = ((v_q << 1) == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            tap_q   <= '0;
            pix_q   <= '0;
            ch_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q <= StRun;
                        tap_q   <= '0;
                        pix_q   <= '0;
                        ch_q    <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                StRun: begin
                    if (in_valid) begin
                        if (!tap_last) begin
                            tap_q <= tap_q + 1'b1;
                        end else begin
                            tap_q <= '0;
                            if (!pix_last) begin
                                pix_q <= pix_q + 1'b1;
                            end else begin
                                pix_q <= '0;
                                if (!ch_last) begin
                                    ch_q <= ch_q + 1'b1;
                                end else begin
                                    ch_q    <= '0;
                                    state_q <= StDrain;
                                end
                            end
                        end
                    end
                end
                StDrain: begin
                    if (line_empty_next) begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    done_q  <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            for (int i = 0; i < WR_DELAY; i++) begin
                addr_q[i] <= '0;
                lane_q[i] <= '0;
            end
        end else begin
            v_q       <= (v_q << 1) | WR_DELAY'(neuron_rdy);
            addr_q[0] <= neuron_rdy ? addr_now : '0;
            lane_q[0] <= neuron_rdy ? lane_now : '0;
            for (int i = 1; i < WR_DELAY; i++) begin
                addr_q[i] <= addr_q[i-1];
                lane_q[i] <= lane_q[i-1];
            end
        end
    end

    assign wr_en   = v_q[WR_DELAY-1];
    assign wr_addr = addr_q[WR_DELAY-1];
    assign wr_lane = lane_q[WR_DELAY-1];
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
